// File: rtl/pb_debounce_repeat_pkg.sv
// Shared types and constants for the push-button debounce/repeat block.
//   NUM_PB     : number of buttons handled by one block
//   pb_state_e : per-button auto-repeat state
//   cnt_width  : width of a counter that must reach max(a,b)-1
package pb_pkg;

  localparam int unsigned NUM_PB = 4;

  typedef enum logic [1:0] {
    PB_IDLE,
    PB_HOLD,
    PB_REPEAT
  } pb_state_e;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/pb_debounce_repeat_if.sv
// Button bundle between the raw board buttons and the conditioned outputs.
//   PUSH_BUTTON_I : raw active-low buttons
//   PB_LEVEL_O    : debounced level, 1 = pressed
//   PB_PRESS_O    : one-cycle pulse on debounced press
//   PB_RELEASE_O  : one-cycle pulse on debounced release
//   PB_REPEAT_O   : one-cycle auto-repeat pulse while held
//   TICK_O        : one-cycle debounce tick
// master = button source / consumer side, slave = pb_debounce_repeat.
interface pb_debounce_repeat_if;
  import pb_pkg::*;

  logic [NUM_PB-1:0] PUSH_BUTTON_I;
  logic [NUM_PB-1:0] PB_LEVEL_O;
  logic [NUM_PB-1:0] PB_PRESS_O;
  logic [NUM_PB-1:0] PB_RELEASE_O;
  logic [NUM_PB-1:0] PB_REPEAT_O;
  logic              TICK_O;

  modport master (
    output PUSH_BUTTON_I,
    input  PB_LEVEL_O, PB_PRESS_O, PB_RELEASE_O, PB_REPEAT_O, TICK_O
  );

  modport slave (
    input  PUSH_BUTTON_I,
    output PB_LEVEL_O, PB_PRESS_O, PB_RELEASE_O, PB_REPEAT_O, TICK_O
  );

endinterface

// File: rtl/pb_debounce_repeat_channel.sv
// One button channel: synchroniser, tick-sampled debounce shift register,
// level/edge detection and hold-to-repeat FSM.
//   clk_i, rst_i : clock, synchronous active-high reset
//   tick_i       : shared debounce tick
//   btn_n_i      : raw active-low button
//   level_o      : debounced level (1 = pressed)
//   press_o      : pulse on debounced rising edge
//   release_o    : pulse on debounced falling edge
//   repeat_o     : auto-repeat pulse while held
module pb_channel
  import pb_pkg::*;
#(
  parameter int unsigned SHIFT_LEN    = 10,
  parameter int unsigned HOLD_TICKS   = 500,
  parameter int unsigned REPEAT_TICKS = 200
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic btn_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int unsigned RW = cnt_width(HOLD_TICKS, REPEAT_TICKS);
  localparam logic [RW-1:0] HOLD_LAST   = RW'(HOLD_TICKS - 1);
  localparam logic [RW-1:0] REPEAT_LAST = RW'(REPEAT_TICKS - 1);

  logic                 sync1_q;
  logic                 sync2_q;
  logic [SHIFT_LEN-1:0] shreg_q;
  logic                 lvl_q;
  logic                 lvl_dly_q;
  pb_state_e            state_q;
  logic [RW-1:0]        rcnt_q;
  logic                 press;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      shreg_q   <= '0;
      lvl_q     <= 1'b0;
      lvl_dly_q <= 1'b0;
    end else begin
      sync1_q   <= ~btn_n_i;
      sync2_q   <= sync1_q;
      if (tick_i) begin
        shreg_q <= {shreg_q[SHIFT_LEN-2:0], sync2_q};
      end
      // Any pressed sample in the window keeps the level up: fast press,
      // release only after SHIFT_LEN quiet ticks.
      lvl_q     <= |shreg_q;
      lvl_dly_q <= lvl_q;
    end
  end

  assign press = lvl_q & ~lvl_dly_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= PB_IDLE;
      rcnt_q  <= '0;
    end else if (!lvl_q) begin
      state_q <= PB_IDLE;
      rcnt_q  <= '0;
    end else begin
      case (state_q)
        PB_IDLE: begin
          if (press) begin
            state_q <= PB_HOLD;
            rcnt_q  <= '0;
          end
        end
        PB_HOLD: begin
          if (tick_i) begin
            if (rcnt_q == HOLD_LAST) begin
              state_q <= PB_REPEAT;
              rcnt_q  <= '0;
            end else begin
              rcnt_q  <= rcnt_q + 1'b1;
            end
          end
        end
        PB_REPEAT: begin
          if (tick_i) begin
            if (rcnt_q == REPEAT_LAST) begin
              rcnt_q <= '0;
            end else begin
              rcnt_q <= rcnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= PB_IDLE;
          rcnt_q  <= '0;
        end
      endcase
    end
  end

  // Gated by lvl_q so a release landing on a repeat tick emits nothing.
  always_comb begin
    repeat_o = 1'b0;
    if (tick_i && lvl_q) begin
      if ((state_q == PB_HOLD && rcnt_q == HOLD_LAST) ||
          (state_q == PB_REPEAT && rcnt_q == REPEAT_LAST)) begin
        repeat_o = 1'b1;
      end
    end
  end

  assign level_o   = lvl_q;
  assign press_o   = press;
  assign release_o = ~lvl_q & lvl_dly_q;

endmodule

// File: rtl/pb_debounce_repeat.sv
// Push-button conditioning: shared debounce-tick prescaler plus one
// pb_channel per button.
//   CLOCK_50_I : system clock
//   RESET_I    : synchronous active-high reset
//   pb         : button bundle (slave side), see pb_debounce_repeat_if
module pb_debounce_repeat
  import pb_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned SHIFT_LEN    = 10,
  parameter int unsigned HOLD_TICKS   = 500,
  parameter int unsigned REPEAT_TICKS = 200
) (
  input  logic                CLOCK_50_I,
  input  logic                RESET_I,
  pb_debounce_repeat_if.slave pb
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0]     tick_cnt_q;
  logic              tick;
  logic [NUM_PB-1:0] level;
  logic [NUM_PB-1:0] press;
  logic [NUM_PB-1:0] release_p;
  logic [NUM_PB-1:0] repeat_p;

  assign tick = (tick_cnt_q == TICK_LAST);

  always_ff @(posedge CLOCK_50_I) begin
    if (RESET_I) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_PB; i++) begin : g_ch
    pb_channel #(
      .SHIFT_LEN    (SHIFT_LEN),
      .HOLD_TICKS   (HOLD_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_ch (
      .clk_i     (CLOCK_50_I),
      .rst_i     (RESET_I),
      .tick_i    (tick),
      .btn_n_i   (pb.PUSH_BUTTON_I[i]),
      .level_o   (level[i]),
      .press_o   (press[i]),
      .release_o (release_p[i]),
      .repeat_o  (repeat_p[i])
    );
  end

  assign pb.PB_LEVEL_O   = level;
  assign pb.PB_PRESS_O   = press;
  assign pb.PB_RELEASE_O = release_p;
  assign pb.PB_REPEAT_O  = repeat_p;
  assign pb.TICK_O       = tick;

endmodule
